// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters,
// sequencing each operation through IDLE -> EXEC -> RESP and returning a tagged response.
module alu_arbiter #(
    parameter int W    = 4,
    parameter int CW   = 3,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [CW-1:0]   req0_ctrl,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic [CW-1:0]   req1_ctrl,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [CW-1:0]   alu_ctrl,
    input  logic [W-1:0]    alu_res,
    input  logic            alu_car,
    input  logic            alu_of,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_res,
    output logic            rsp_car,
    output logic            rsp_of,
    output logic            busy,
    output logic [CNTW-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            cur_id_q, cur_id_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [CW-1:0]   op_ctrl_q, op_ctrl_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_res_q, rsp_res_d;
    logic            rsp_car_q, rsp_car_d;
    logic            rsp_of_q, rsp_of_d;
    logic [CNTW-1:0] done_cnt_q, done_cnt_d;
    logic            grant0_s, grant1_s;

    // Arbitration winner: a lone requester wins, otherwise the one not granted last.
    always_comb begin
        grant0_s = req0_valid && (!req1_valid || last_grant_q);
        grant1_s = req1_valid && (!req0_valid || !last_grant_q);
    end

    assign req0_ready = (state_q == IDLE) && grant0_s;
    assign req1_ready = (state_q == IDLE) && grant1_s;
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_ctrl   = op_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_res    = rsp_res_q;
    assign rsp_car    = rsp_car_q;
    assign rsp_of     = rsp_of_q;
    assign busy       = (state_q != IDLE);
    assign done_cnt   = done_cnt_q;

    // Next-state and datapath updates for the accept / execute / respond sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_car_d    = rsp_car_q;
        rsp_of_d     = rsp_of_q;
        done_cnt_d   = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant0_s) begin
                    op_a_d       = req0_a;
                    op_b_d       = req0_b;
                    op_ctrl_d    = req0_ctrl;
                    last_grant_d = 1'b0;
                    cur_id_d     = 1'b0;
                    state_d      = EXEC;
                end else if (grant1_s) begin
                    op_a_d       = req1_a;
                    op_b_d       = req1_b;
                    op_ctrl_d    = req1_ctrl;
                    last_grant_d = 1'b1;
                    cur_id_d     = 1'b1;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_res_d   = alu_res;
                rsp_car_d   = alu_car;
                rsp_of_d    = alu_of;
                rsp_id_d    = cur_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Returning to IDLE here keeps a new accept out of the handshake cycle.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNTW'(1);
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_car_q    <= 1'b0;
            rsp_of_q     <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_car_q    <= rsp_car_d;
            rsp_of_q     <= rsp_of_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

endmodule
